// File: rtl/gray_decoder.sv
// ============================================================================
// gray_decoder: gray-to-binary receiver with single-step stream checking,
// saturating wrap counter and sticky error/overflow flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gray_decoder #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Valid,
  input  logic [WIDTH-1:0] GrayIn,
  input  logic             Resync,
  output logic [WIDTH-1:0] Binary,
  output logic             OutValid,
  output logic             Locked,
  output logic             Error,
  output logic             Overflow,
  output logic [CNT_W-1:0] WrapCount
);

  localparam logic [1:0] S_UNLOCKED = 2'd0;
  localparam logic [1:0] S_LOCKED   = 2'd1;
  localparam logic [1:0] S_ERROR    = 2'd2;

  localparam logic [WIDTH-1:0] C_BIN_MAX = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_binary;
  logic             r_out_valid;
  logic             r_overflow;
  logic [CNT_W-1:0] r_wrap_cnt;
  logic [WIDTH-1:0] w_dec;
  logic             w_hold;
  logic             w_step;
  logic             w_wrap;

  // Prefix-XOR from the MSB down.
  always_comb begin
    w_dec[WIDTH-1] = GrayIn[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      w_dec[i] = w_dec[i+1] ^ GrayIn[i];
    end
  end

  assign w_hold = (w_dec == r_binary);
  assign w_step = (r_binary != C_BIN_MAX) && (w_dec == r_binary + WIDTH'(1));
  assign w_wrap = (r_binary == C_BIN_MAX) && (w_dec == '0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_UNLOCKED;
      r_binary    <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_wrap_cnt  <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (Resync) begin
        // A sample on the resync edge relocks immediately, with no wrap check.
        if (Valid) begin
          r_binary    <= w_dec;
          r_out_valid <= 1'b1;
          r_state     <= S_LOCKED;
        end else begin
          r_state <= S_UNLOCKED;
        end
      end else if (Valid) begin
        case (r_state)
          S_UNLOCKED: begin
            r_binary    <= w_dec;
            r_out_valid <= 1'b1;
            r_state     <= S_LOCKED;
          end
          S_LOCKED: begin
            if (w_hold || w_step) begin
              r_binary    <= w_dec;
              r_out_valid <= 1'b1;
            end else if (w_wrap) begin
              r_binary    <= '0;
              r_out_valid <= 1'b1;
              r_overflow  <= 1'b1;
              if (r_wrap_cnt != C_CNT_MAX) begin
                r_wrap_cnt <= r_wrap_cnt + CNT_W'(1);
              end
            end else begin
              r_state <= S_ERROR;
            end
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

  assign Binary    = r_binary;
  assign OutValid  = r_out_valid;
  assign Locked    = (r_state == S_LOCKED);
  assign Error     = (r_state == S_ERROR);
  assign Overflow  = r_overflow;
  assign WrapCount = r_wrap_cnt;

endmodule

`default_nettype wire

// File: doc/gray_decoder.md
Name: gray_decoder

Overview:
Receive-side counterpart to the gray-code counter. Each time Valid is high, the block samples a gray-code word and converts it to binary. It also checks that the stream follows legal single-step counter behaviour: hold, or advance by one with wrap. It counts wrap-arounds and flags illegal transitions. It sits between a gray-coded producer (counter or pointer crossing) and binary-consuming logic.

Parameters:
WIDTH, 3, width of gray input and binary output
CNT_W, 8, width of the saturating wrap counter

Ports:
Clk  input  1  clock, all state updates on posedge
Reset  input  1  synchronous, active-high; clears all state
Valid  input  1  GrayIn is sampled on this edge
GrayIn  input  WIDTH  gray-code word from producer
Resync  input  1  leave ERROR and relock; clears Error
Binary  output  WIDTH  decoded binary of the last accepted sample
OutValid  output  1  one-cycle pulse per accepted sample
Locked  output  1  high while state is LOCKED
Error  output  1  sticky; high while state is ERROR
Overflow  output  1  sticky; set on the first max->0 wrap
WrapCount  output  CNT_W  saturating count of max->0 wraps

Behaviour:
- Reset: clocking: Clk. Reset is synchronous, active-high.
- Reset values: Binary=0, OutValid=0, Locked=0, Error=0, Overflow=0, WrapCount=0, state=UNLOCKED.
- Conversion (combinational, internal): b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] for i=WIDTH-2..0. Call the result D.
- Latency: all outputs are registered. A sample taken on edge N shows on Binary/OutValid/flags after edge N, for one cycle in the case of OutValid.
- Priority: Reset > Resync > Valid.
- States:
  - UNLOCKED:
    - Valid=1 -> accept: Binary<=D, OutValid<=1, go to LOCKED.
    - No wrap check is made on the first sample.
  - LOCKED, on Valid=1, with P = current Binary:
    - D==P (hold): accept, OutValid<=1, Binary unchanged.
    - D==P+1 with P<2^WIDTH-1: accept, Binary<=D.
    - P==2^WIDTH-1 and D==0 (wrap): accept, Binary<=0, Overflow<=1, WrapCount<=WrapCount+1. WrapCount saturates at 2^CNT_W-1.
    - Any other D (skip, backward step, multi-bit change): reject. Binary holds, OutValid<=0, Error<=1, Locked<=0, go to ERROR.
  - ERROR:
    - All Valid samples are ignored: no OutValid, no Binary update.
    - Stays in ERROR until Resync or Reset.
- Resync (any state):
  - Error<=0.
  - If Valid=1 on the same edge: the sample is accepted as a first sample (as in UNLOCKED) and the state goes to LOCKED.
  - Otherwise the state goes to UNLOCKED and Locked<=0.
  - Overflow and WrapCount are not affected by Resync.
- Valid=0: OutValid<=0; all other state holds.
- Reset mid-stream: every output returns to its reset value on that edge. The Valid sample on that edge is discarded.
- Locked is the registered state decode: 1 exactly when in LOCKED.

Test Plan:
1. WIDTH=3. After reset, Valid=1 with GrayIn 000,001,011,010,110,111,101,100,000 on consecutive cycles -> Binary 0,1,2,3,4,5,6,7,0. OutValid=1 each cycle. Locked=1 from the first sample. Overflow=1 and WrapCount=1 after the final 000. Error=0 throughout.
2. Hold: GrayIn 011 presented for 3 cycles, then Valid=0 for 2 cycles -> Binary=2 held, OutValid=1 for 3 cycles then 0, Error=0.
3. Illegal step: lock at 011 (Binary=2), then feed 110 -> Error=1, Locked=0, Binary stays 2, OutValid=0. Then feed 010 -> still ignored, Binary=2.
4. Resync: from ERROR, Resync=1 with Valid=1 and GrayIn=111 -> Error=0, Locked=1, Binary=5, OutValid=1. Overflow/WrapCount unchanged. Separately, Resync with Valid=0 -> Locked=0 and state UNLOCKED; next sample 101 -> Binary=6 with no wrap counted.
5. Saturation: CNT_W=2, run 5 full gray cycles -> WrapCount reaches 3 and stays 3, Overflow=1.
6. Reset mid-stream: at Binary=4, assert Reset together with Valid=1 and GrayIn=111 -> next cycle all outputs are 0 and Locked=0. The next sample 101 is accepted as a first sample: Binary=6, no wrap.
